// File: rtl/fetch_stage_ctrl_pkg.sv
// Shared constants for the fetch stage: datapath width, reset PC, bubble encoding
// and the sequential fetch increment.
package fetch_stage_ctrl_pkg;

   localparam int unsigned DEFAULT_XLEN      = 32;
   localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
   // addi x0, x0, 0
   localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
   localparam int unsigned DEFAULT_CNT_W     = 32;
   localparam int unsigned PC_INCR           = 4;

endpackage : fetch_stage_ctrl_pkg

// File: rtl/fetch_stage_ctrl_sat_counter.sv
// Saturating up-counter used for the fetch-stage debug event counters.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset, clears the count
//   inc   - count one event on this edge
//   count - current count, sticks at all-ones
module sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + {{(W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule : sat_counter

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage control: owns the PC and the IF/ID pipeline register. Each cycle
// it advances, holds (load-use stall) or squashes (EX redirect) the front end.
// Ports:
//   clk, rst_n         - clock and asynchronous active-low reset
//   PCWrite            - 1 lets the PC advance, 0 holds it
//   Write_IFID         - 1 lets IF/ID load, 0 holds it
//   PCSrcE, PCTargetE  - taken redirect from EX and its target
//   imem_rdata         - instruction at pc_F (combinational memory)
//   pc_F               - fetch PC / imem address
//   instr_IFID, pc_IFID, pc_plus4_IFID, valid_IFID - IF/ID register contents
//   misalign_err       - sticky: some redirect target was not word aligned
//   stall_cnt, flush_cnt - saturating event counters
module fetch_stage_ctrl
   import fetch_stage_ctrl_pkg::*;
#(
   parameter int unsigned      XLEN      = DEFAULT_XLEN,
   parameter logic [XLEN-1:0]  RESET_PC  = XLEN'(DEFAULT_RESET_PC),
   parameter logic [31:0]      NOP_INSTR = DEFAULT_NOP_INSTR,
   parameter int unsigned      CNT_W     = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             PCWrite,
   input  logic             Write_IFID,
   input  logic             PCSrcE,
   input  logic [XLEN-1:0]  PCTargetE,
   input  logic [31:0]      imem_rdata,
   output logic [XLEN-1:0]  pc_F,
   output logic [31:0]      instr_IFID,
   output logic [XLEN-1:0]  pc_IFID,
   output logic [XLEN-1:0]  pc_plus4_IFID,
   output logic             valid_IFID,
   output logic             misalign_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   logic [XLEN-1:0] pc_q, pc_d, pc_seq;
   logic [31:0]     instr_q, instr_d;
   logic [XLEN-1:0] pc_id_q, pc_id_d;
   logic [XLEN-1:0] pc4_id_q, pc4_id_d;
   logic            valid_q, valid_d;
   logic            misalign_q, misalign_d;
   logic            stall_evt;

   assign pc_seq = pc_q + XLEN'(PC_INCR);

   always_comb begin
      pc_d       = pc_q;
      instr_d    = instr_q;
      pc_id_d    = pc_id_q;
      pc4_id_d   = pc4_id_q;
      valid_d    = valid_q;
      misalign_d = misalign_q;

      if (PCSrcE) begin
         // Low bits are dropped; a non-zero pair is only reported, never honoured.
         pc_d       = {PCTargetE[XLEN-1:2], 2'b00};
         misalign_d = misalign_q | (PCTargetE[1:0] != 2'b00);
      end else if (PCWrite) begin
         pc_d = pc_seq;
      end

      // The flush beats a held IF/ID: whatever is held there is wrong-path.
      if (PCSrcE) begin
         instr_d  = NOP_INSTR;
         pc_id_d  = '0;
         pc4_id_d = '0;
         valid_d  = 1'b0;
      end else if (Write_IFID) begin
         instr_d  = imem_rdata;
         pc_id_d  = pc_q;
         pc4_id_d = pc_seq;
         valid_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         instr_q    <= NOP_INSTR;
         pc_id_q    <= '0;
         pc4_id_q   <= '0;
         valid_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         pc_id_q    <= pc_id_d;
         pc4_id_q   <= pc4_id_d;
         valid_q    <= valid_d;
         misalign_q <= misalign_d;
      end
   end

   // A redirect on a stall cycle counts as a flush only.
   assign stall_evt = !PCWrite && !PCSrcE;

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_evt),
      .count (stall_cnt)
   );

   sat_counter #(
      .W (CNT_W)
   ) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (PCSrcE),
      .count (flush_cnt)
   );

   assign pc_F          = pc_q;
   assign instr_IFID    = instr_q;
   assign pc_IFID       = pc_id_q;
   assign pc_plus4_IFID = pc4_id_q;
   assign valid_IFID    = valid_q;
   assign misalign_err  = misalign_q;

endmodule : fetch_stage_ctrl

// File: tb/tb_fetch_stage_ctrl.sv
// Bench for fetch_stage_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_fetch_stage_ctrl;

   localparam int unsigned CW      = 4;
   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [31:0] TAG     = 32'hC0DE_0000;
   localparam int          CNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          PCWrite = 1'b1;
   logic          Write_IFID = 1'b1;
   logic          PCSrcE = 1'b0;
   logic [31:0]   PCTargetE = '0;
   logic [31:0]   imem_rdata;
   logic [31:0]   pc_F, instr_IFID, pc_IFID, pc_plus4_IFID;
   logic          valid_IFID, misalign_err;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int errors = 0;
   int checks = 0;
   bit en     = 1'b0;

   always #5 clk = ~clk;

   // Instruction memory returns a word tagged with its own address.
   assign imem_rdata = pc_F ^ TAG;

   fetch_stage_ctrl #(
      .XLEN      (32),
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (NOP),
      .CNT_W     (CW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .PCWrite       (PCWrite),
      .Write_IFID    (Write_IFID),
      .PCSrcE        (PCSrcE),
      .PCTargetE     (PCTargetE),
      .imem_rdata    (imem_rdata),
      .pc_F          (pc_F),
      .instr_IFID    (instr_IFID),
      .pc_IFID       (pc_IFID),
      .pc_plus4_IFID (pc_plus4_IFID),
      .valid_IFID    (valid_IFID),
      .misalign_err  (misalign_err),
      .stall_cnt     (stall_cnt),
      .flush_cnt     (flush_cnt)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_pc, m_instr, m_pcid, m_pc4;
   bit          m_valid, m_mis;
   int          m_stall, m_flush;

   function automatic logic [31:0] wrap4(input logic [31:0] a);
      logic [63:0] s;
      s = (64'(a) + 64'd4) % 64'h1_0000_0000;
      return s[31:0];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc <= '0; m_instr <= NOP; m_pcid <= '0; m_pc4 <= '0;
         m_valid <= 1'b0; m_mis <= 1'b0; m_stall <= 0; m_flush <= 0;
      end else if (PCSrcE) begin
         m_pc    <= PCTargetE & ~32'h3;
         m_instr <= NOP; m_pcid <= '0; m_pc4 <= '0; m_valid <= 1'b0;
         if (PCTargetE % 4 != 0) m_mis <= 1'b1;
         m_flush <= (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
      end else begin
         if (PCWrite) m_pc <= wrap4(m_pc);
         else m_stall <= (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
         if (Write_IFID) begin
            m_instr <= m_pc ^ TAG; m_pcid <= m_pc; m_pc4 <= wrap4(m_pc); m_valid <= 1'b1;
         end
      end
   end

   // Per-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      if (en && rst_n) begin
         chk("pc_F", 64'(pc_F), 64'(m_pc));
         chk("instr_IFID", 64'(instr_IFID), 64'(m_instr));
         chk("pc_IFID", 64'(pc_IFID), 64'(m_pcid));
         chk("pc_plus4_IFID", 64'(pc_plus4_IFID), 64'(m_pc4));
         chk("valid_IFID", 64'(valid_IFID), 64'(m_valid));
         chk("misalign_err", 64'(misalign_err), 64'(m_mis));
         chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
         chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
      end
   end

   // ---------------- directed helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input bit pw, input bit wi, input bit src, input logic [31:0] tgt);
      PCWrite = pw; Write_IFID = wi; PCSrcE = src; PCTargetE = tgt;
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_pc_F"}, 64'(pc_F), 64'h0);
      chk({tag, "_instr"}, 64'(instr_IFID), 64'h13);
      chk({tag, "_pc_IFID"}, 64'(pc_IFID), 64'h0);
      chk({tag, "_pc4"}, 64'(pc_plus4_IFID), 64'h0);
      chk({tag, "_valid"}, 64'(valid_IFID), 64'h0);
      chk({tag, "_mis"}, 64'(misalign_err), 64'h0);
      chk({tag, "_stall"}, 64'(stall_cnt), 64'h0);
      chk({tag, "_flush"}, 64'(flush_cnt), 64'h0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #2;
      reset_checks("rst");
      rst_n = 1'b1;
      en    = 1'b1;

      // Free running from reset.
      drive(1, 1, 0, 0);
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk("run_pc_F", 64'(pc_F), 64'(4 * i));
         chk("run_pc_IFID", 64'(pc_IFID), 64'(4 * (i - 1)));
         chk("run_instr", 64'(instr_IFID), 64'((32'(4 * (i - 1))) ^ TAG));
         chk("run_valid", 64'(valid_IFID), 64'h1);
      end

      // Load-use stall at pc 0x10.
      tick();
      drive(0, 0, 0, 0);
      tick(); tick();
      chk("stall_pc_F", 64'(pc_F), 64'h10);
      chk("stall_pc_IFID", 64'(pc_IFID), 64'hC);
      chk("stall_cnt2", 64'(stall_cnt), 64'd2);
      drive(1, 1, 0, 0);
      tick();
      chk("resume_pc_F", 64'(pc_F), 64'h14);

      // Redirect at pc 0x20.
      tick(); tick(); tick();
      chk("pre_redir_pc", 64'(pc_F), 64'h20);
      drive(1, 1, 1, 32'h100);
      tick();
      chk("redir_pc_F", 64'(pc_F), 64'h100);
      chk("redir_valid", 64'(valid_IFID), 64'h0);
      chk("redir_instr", 64'(instr_IFID), 64'h13);
      chk("redir_flush", 64'(flush_cnt), 64'd1);
      drive(1, 1, 0, 0);
      tick();
      chk("tgt_pc_IFID", 64'(pc_IFID), 64'h100);
      chk("tgt_valid", 64'(valid_IFID), 64'h1);

      // Redirect together with a stall.
      drive(0, 0, 1, 32'h40);
      tick();
      chk("both_pc_F", 64'(pc_F), 64'h40);
      chk("both_valid", 64'(valid_IFID), 64'h0);
      chk("both_stall", 64'(stall_cnt), 64'd2);
      chk("both_flush", 64'(flush_cnt), 64'd2);

      // Misaligned target, sticky flag.
      drive(1, 1, 1, 32'h102);
      tick();
      chk("mis_pc_F", 64'(pc_F), 64'h100);
      chk("mis_flag", 64'(misalign_err), 64'h1);
      drive(1, 1, 0, 0);
      repeat (10) tick();
      chk("mis_sticky", 64'(misalign_err), 64'h1);

      // PC wrap.
      drive(1, 1, 1, 32'hFFFF_FFFC);
      tick();
      chk("wrap_pre", 64'(pc_F), 64'hFFFF_FFFC);
      drive(1, 1, 0, 0);
      tick();
      chk("wrap_pc_F", 64'(pc_F), 64'h0);
      chk("wrap_pc4", 64'(pc_plus4_IFID), 64'h0);

      // Stall counter saturation (4-bit counters).
      drive(0, 1, 0, 0);
      repeat (12) tick();
      chk("sat_14", 64'(stall_cnt), 64'd14);
      repeat (3) tick();
      chk("sat_15", 64'(stall_cnt), 64'd15);

      // Mid-redirect asynchronous reset.
      drive(0, 0, 1, 32'h200);
      rst_n = 1'b0;
      #1;
      reset_checks("midrst");
      tick();
      drive(1, 1, 0, 0);
      rst_n = 1'b1;

      // Randomized traffic, with occasional resets.
      for (int n = 0; n < 3000; n++) begin
         PCWrite    = ($urandom_range(3) != 0);
         Write_IFID = ($urandom_range(3) != 0);
         PCSrcE     = ($urandom_range(7) == 0);
         PCTargetE  = ($urandom_range(5) == 0) ? $urandom() : ($urandom() & ~32'h3);
         if ($urandom_range(4) == 0) PCTargetE = 32'hFFFF_FFF0 | ($urandom() & 32'hC);
         rst_n      = ($urandom_range(199) != 0);
         tick();
      end

      rst_n = 1'b1;
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_fetch_stage_ctrl
